// File: rtl/axis_pkg.sv
// Shared AXI4-Stream helpers: TKEEP width derivation and beat field layout.
// A stored beat is packed as {TLAST, TUSER, TKEEP, TDATA}, with TDATA at bit 0.
// Ports: none (package).
package axis_pkg;

   // Byte-qualifier width for a given TDATA width.
   function automatic int unsigned keep_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Bit offsets of each field inside a packed beat.
   localparam int unsigned OFF_DATA = 0;

   function automatic int unsigned off_keep(input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned off_user(input int unsigned data_w);
      return data_w + keep_w(data_w);
   endfunction

   function automatic int unsigned off_last(input int unsigned data_w,
                                            input int unsigned user_w);
      return data_w + keep_w(data_w) + user_w;
   endfunction

   // Total width of one packed beat.
   function automatic int unsigned beat_w(input int unsigned data_w,
                                          input int unsigned user_w);
      return data_w + keep_w(data_w) + user_w + 1;
   endfunction

endpackage

// File: rtl/axis_buf_ram.sv
// Beat storage for axis_buf: DEPTH x WIDTH register array.
// Ports:
//   clk_i    clock
//   we_i     write enable (sync write on posedge)
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address (asynchronous read)
//   rdata_c  read data, combinational from the array
// Contents are intentionally not reset.
module axis_buf_ram #(
   parameter int unsigned WIDTH = 74,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_c
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Single synchronous write port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/axis_buf.sv
// AXI4-Stream elastic buffer, DEPTH beats of {TLAST,TUSER,TKEEP,TDATA}.
// Full throughput; s_TREADY and m_TVALID come from registers only, so there
// is no combinational path from m_TREADY to s_TREADY.
// Optional store-and-forward: define AXIS_BUF_PKT_MODE_EN to hold output
// until a complete packet is stored (or the buffer is full).
// Ports:
//   ACLK, ARESET               clock, synchronous active-high reset
//   s_TVALID/s_TREADY/s_T*     upstream slave stream
//   m_TVALID/m_TREADY/m_T*     downstream master stream
//   level                      beats currently stored, 0..DEPTH
module axis_buf
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned USER_W = 1,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     s_TVALID,
   output logic                     s_TREADY,
   input  logic [DATA_W-1:0]        s_TDATA,
   input  logic [DATA_W/8-1:0]      s_TKEEP,
   input  logic [USER_W-1:0]        s_TUSER,
   input  logic                     s_TLAST,
   output logic                     m_TVALID,
   input  logic                     m_TREADY,
   output logic [DATA_W-1:0]        m_TDATA,
   output logic [DATA_W/8-1:0]      m_TKEEP,
   output logic [USER_W-1:0]        m_TUSER,
   output logic                     m_TLAST,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned KEEP_W = keep_w(DATA_W);
   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned PW     = AW + 1;
   localparam int unsigned BEAT_W = beat_w(DATA_W, USER_W);
   localparam int unsigned O_KEEP = off_keep(DATA_W);
   localparam int unsigned O_USER = off_user(DATA_W);
   localparam int unsigned O_LAST = off_last(DATA_W, USER_W);

   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d, level_q, level_d;
   logic              s_tready_q, s_tready_d, m_tvalid_q, m_tvalid_d;
   logic              wr_en, rd_en, empty_d, full_d;
   logic [BEAT_W-1:0] wbeat, rbeat;

   assign wr_en = s_TVALID && s_tready_q;
   assign rd_en = m_tvalid_q && m_TREADY;

   // Pack the incoming beat.
   always_comb begin
      wbeat                       = '0;
      wbeat[OFF_DATA +: DATA_W]   = s_TDATA;
      wbeat[O_KEEP   +: KEEP_W]   = s_TKEEP;
      wbeat[O_USER   +: USER_W]   = s_TUSER;
      wbeat[O_LAST]               = s_TLAST;
   end

   axis_buf_ram #(
      .WIDTH (BEAT_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (ACLK),
      .we_i    (wr_en),
      .waddr_i (wr_q[AW-1:0]),
      .wdata_i (wbeat),
      .raddr_i (rd_q[AW-1:0]),
      .rdata_c (rbeat)
   );

   assign m_TDATA = rbeat[OFF_DATA +: DATA_W];
   assign m_TKEEP = rbeat[O_KEEP   +: KEEP_W];
   assign m_TUSER = rbeat[O_USER   +: USER_W];
   assign m_TLAST = rbeat[O_LAST];

`ifdef AXIS_BUF_PKT_MODE_EN
   logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          pkt_in, pkt_out;

   assign pkt_in  = wr_en && s_TLAST;
   assign pkt_out = rd_en && m_TLAST;

   // Count of complete packets held; in and out in one cycle cancel.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (pkt_in && !pkt_out) begin
         pkt_cnt_d = pkt_cnt_q + PW'(1);
      end else if (!pkt_in && pkt_out) begin
         pkt_cnt_d = pkt_cnt_q - PW'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         pkt_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end
`endif

   // Next pointer state; flags are derived from next state so the
   // handshake outputs can be registered without losing a cycle.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (wr_en) begin
         wr_d = wr_q + PW'(1);
      end
      if (rd_en) begin
         rd_d = rd_q + PW'(1);
      end
      empty_d    = (wr_d == rd_d);
      full_d     = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
      level_d    = wr_d - rd_d;
      s_tready_d = !full_d;
`ifdef AXIS_BUF_PKT_MODE_EN
      // The full term releases packets longer than DEPTH.
      m_tvalid_d = !empty_d && ((pkt_cnt_d != '0) || full_d);
`else
      m_tvalid_d = !empty_d;
`endif
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_q       <= '0;
         rd_q       <= '0;
         level_q    <= '0;
         s_tready_q <= 1'b0;
         m_tvalid_q <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         level_q    <= level_d;
         s_tready_q <= s_tready_d;
         m_tvalid_q <= m_tvalid_d;
      end
   end

   assign s_TREADY = s_tready_q;
   assign m_TVALID = m_tvalid_q;
   assign level    = level_q;

endmodule

// File: tb/tb_axis_buf.sv
// Self-checking bench for axis_buf (DATA_W=64, USER_W=1, DEPTH=4).
// Directed sequences with hand-derived expectations plus an in-order
// scoreboard on every output handshake. Pass -DAXIS_BUF_PKT_MODE_EN to
// exercise store-and-forward mode as well.
module tb_axis_buf;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned USER_W = 1;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned BW     = DATA_W + DATA_W/8 + USER_W + 1;
   localparam int          N_RND  = 10000;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic              s_TVALID, s_TREADY, s_TLAST;
   logic [DATA_W-1:0] s_TDATA;
   logic [7:0]        s_TKEEP;
   logic [0:0]        s_TUSER;
   logic              m_TVALID, m_TREADY, m_TLAST;
   logic [DATA_W-1:0] m_TDATA;
   logic [7:0]        m_TKEEP;
   logic [0:0]        m_TUSER;
   logic [2:0]        level;

   int n_checks = 0;
   int n_fail   = 0;
   logic [BW-1:0] sb [$];
   logic wr_seen, rd_seen;

   axis_buf #(.DATA_W(DATA_W), .USER_W(USER_W), .DEPTH(DEPTH)) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .s_TVALID (s_TVALID),
      .s_TREADY (s_TREADY),
      .s_TDATA  (s_TDATA),
      .s_TKEEP  (s_TKEEP),
      .s_TUSER  (s_TUSER),
      .s_TLAST  (s_TLAST),
      .m_TVALID (m_TVALID),
      .m_TREADY (m_TREADY),
      .m_TDATA  (m_TDATA),
      .m_TKEEP  (m_TKEEP),
      .m_TUSER  (m_TUSER),
      .m_TLAST  (m_TLAST),
      .level    (level)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock: score handshakes seen before the edge, then advance to #1 after it.
   task automatic step();
      logic [BW-1:0] exp_b;
      logic          rst;
      rst     = ARESET;
      wr_seen = s_TVALID && s_TREADY;
      rd_seen = m_TVALID && m_TREADY;
      if (rd_seen) begin
         if (sb.size() == 0) begin
            chk("out_without_input", 128'(rd_seen), 128'(0));
         end else begin
            exp_b = sb.pop_front();
            chk("out_beat", 128'({m_TLAST, m_TUSER, m_TKEEP, m_TDATA}), 128'(exp_b));
         end
      end
      if (wr_seen) sb.push_back({s_TLAST, s_TUSER, s_TKEEP, s_TDATA});
      @(posedge ACLK);
      #1;
      if (rst) sb.delete();
   endtask

   task automatic set_beat(input logic [63:0] d, input logic last);
      s_TVALID = 1'b1;
      s_TDATA  = d;
      s_TKEEP  = d[7:0] ^ 8'hA5;
      s_TUSER  = d[0];
      s_TLAST  = last;
   endtask

   // Present one beat and hold it until accepted.
   task automatic send(input logic [63:0] d, input logic last);
      int n;
      set_beat(d, last);
      n = 0;
      do begin
         step();
         n++;
      end while (!wr_seen && n < 20);
      chk("send_accepted", 128'(wr_seen), 128'(1));
      s_TVALID = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      s_TVALID = 1'b0;
      m_TREADY = 1'b1;
      n = 0;
      while (level != 3'd0 && n < 20) begin
         step();
         n++;
      end
      chk(tag, 128'(level), 128'(0));
      chk({tag, "_sb"}, 128'(sb.size()), 128'(0));
   endtask

   initial begin
      int sent, cyc;
      ARESET   = 1'b1;
      s_TVALID = 1'b0;
      s_TDATA  = '0;
      s_TKEEP  = '0;
      s_TUSER  = '0;
      s_TLAST  = 1'b0;
      m_TREADY = 1'b0;

      // Reset held two cycles, then released.
      step();
      step();
      chk("rst_mvalid", 128'(m_TVALID), 128'(0));
      chk("rst_sready", 128'(s_TREADY), 128'(0));
      chk("rst_level",  128'(level),    128'(0));
      ARESET = 1'b0;
      step();
      chk("rel_sready", 128'(s_TREADY), 128'(1));
      chk("rel_level",  128'(level),    128'(0));
      chk("rel_mvalid", 128'(m_TVALID), 128'(0));

      // Fill with TDATA 1..4 while downstream stalls.
      for (int i = 1; i <= 4; i++) begin
         set_beat(64'(i), 1'b1);
         step();
         chk("fill_level",  128'(level),    128'(i));
         chk("fill_mvalid", 128'(m_TVALID), 128'(1));
         chk("fill_head",   128'(m_TDATA),  128'(1));
         chk("fill_sready", 128'(s_TREADY), 128'(i < 4));
      end
      set_beat(64'd5, 1'b1);
      step();
      chk("fifth_level",  128'(level),    128'(4));
      chk("fifth_sready", 128'(s_TREADY), 128'(0));
      chk("fifth_head",   128'(m_TDATA),  128'(1));

      // Full with simultaneous read: s_TREADY stays low this cycle, rises next.
      m_TREADY = 1'b1;
      chk("fr_sready0", 128'(s_TREADY), 128'(0));
      step();
      chk("fr_level1",  128'(level),    128'(3));
      chk("fr_sready1", 128'(s_TREADY), 128'(1));
      chk("fr_head1",   128'(m_TDATA),  128'(2));
      step();
      chk("fr_level2",  128'(level),    128'(3));
      chk("fr_head2",   128'(m_TDATA),  128'(3));
      set_beat(64'd6, 1'b1);
      step();
      chk("fr_level3",  128'(level),    128'(3));
      chk("fr_head3",   128'(m_TDATA),  128'(4));
      drain("fr_drain");

      // Streaming: one beat per cycle, latency one, level stays at one.
      for (int i = 0; i < 100; i++) begin
         set_beat(64'(1000 + i), 1'b1);
         step();
         chk("str_level",  128'(level),    128'(1));
         chk("str_mvalid", 128'(m_TVALID), 128'(1));
         chk("str_data",   128'(m_TDATA),  128'(1000 + i));
      end
      s_TVALID = 1'b0;
      step();
      chk("str_end_level", 128'(level), 128'(0));

      // Reset mid-packet discards stored beats.
      m_TREADY = 1'b0;
      send(64'h77, 1'b0);
      send(64'h78, 1'b0);
      chk("mid_level", 128'(level), 128'(2));
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      chk("mid_rst_level",  128'(level),    128'(0));
      chk("mid_rst_mvalid", 128'(m_TVALID), 128'(0));
      step();
      chk("mid_rel_sready", 128'(s_TREADY), 128'(1));
      chk("mid_rel_mvalid", 128'(m_TVALID), 128'(0));

`ifdef AXIS_BUF_PKT_MODE_EN
      // Store-and-forward: output waits for TLAST.
      m_TREADY = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         send(64'(200 + i), i == 3);
         chk("pkt3_mvalid", 128'(m_TVALID), 128'(i == 3));
      end
      drain("pkt3_drain");
      // A packet longer than DEPTH is released once the buffer is full.
      for (int i = 1; i <= 6; i++) begin
         send(64'(300 + i), i == 6);
         if (i <= 4) begin
            chk("pkt6_mvalid", 128'(m_TVALID), 128'(i == 4));
            chk("pkt6_level",  128'(level),    128'(i));
         end
      end
      drain("pkt6_drain");
`endif

      // Random valid/ready with full scoreboard; last beat closes the packet.
      sent = 0;
      cyc  = 0;
      while ((sent < N_RND || sb.size() != 0) && cyc < 60000) begin
         if (sent < N_RND && $urandom_range(3) != 0) begin
            s_TVALID = 1'b1;
            s_TDATA  = {$urandom, $urandom};
            s_TKEEP  = 8'($urandom);
            s_TUSER  = 1'($urandom);
            s_TLAST  = (sent == N_RND - 1) ? 1'b1 : 1'($urandom);
         end else begin
            s_TVALID = 1'b0;
         end
         m_TREADY = ($urandom_range(3) != 0);
         step();
         if (wr_seen) sent++;
         chk("rnd_level", 128'(level), 128'(sb.size()));
         cyc++;
      end
      chk("rnd_sent", 128'(sent),      128'(N_RND));
      chk("rnd_left", 128'(sb.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
